// File: rtl/cnt_bus_pkg.sv
// Shared definitions for the trigger-counter bus controller: default widths,
// FSM state codes and the bus-ownership encoding.
package cnt_bus_pkg;

  localparam int N_DEF = 3;
  localparam int P_DEF = 4;

  // cnt_we value at which the counter owns (drives) the shared bus.
  localparam logic CNT_OWNS = 1'b1;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_LOAD = 3'd1;
  localparam state_t ST_ARM  = 3'd2;
  localparam state_t ST_RUN  = 3'd3;
  localparam state_t ST_STOP = 3'd4;

endpackage

// File: rtl/cnt_bus_ctrl.sv
// Host-side controller for the shared count/load bus of the N-bit trigger
// counter. A run loads the limit, issues one trigger edge, hands the bus to
// the counter while sampling the live count, counts wrap pulses and stops
// after the programmed number of periods (or on abort).
module cnt_bus_ctrl
  import cnt_bus_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int P = P_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [N-1:0] limit,
  input  logic [P-1:0] periods,
  inout  wire  [N-1:0] cnt_bus,
  output logic         cnt_we,
  output logic         cnt_trig,
  input  logic         cnt_pulse,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] count_q,
  output logic [P-1:0] periods_seen
);

  state_t       state;
  state_t       state_nx;
  logic [N-1:0] limit_q;
  logic [P-1:0] periods_q;
  logic [P-1:0] seen_inc;
  logic         last_pulse;
  logic         drive_en;

  // The host drives exactly when the counter does not; both follow cnt_we,
  // which is itself a registered decode of the next state. The bus always
  // carries limit_q so the counter's load value is stable outside RUN.
  assign drive_en = (cnt_we != CNT_OWNS);
  assign cnt_bus  = drive_en ? limit_q : {N{1'bz}};

  // Next-state decode and saturating period increment.
  always_comb begin
    // NOTE: every variable gets a default first so no path can leave it
    // unassigned, which would otherwise infer a latch.
    state_nx   = state;
    seen_inc   = (&periods_seen) ? periods_seen : periods_seen + 1'b1;
    last_pulse = cnt_pulse && (seen_inc == periods_q);

    case (state)
      ST_IDLE: if (start) state_nx = ST_LOAD;
      ST_LOAD: state_nx = abort ? ST_STOP : ST_ARM;
      ST_ARM: begin
        if (abort || (periods_q == '0)) state_nx = ST_STOP;
        else                            state_nx = ST_RUN;
      end
      ST_RUN:  if (abort || last_pulse) state_nx = ST_STOP;
      ST_STOP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // State, registered outputs and run bookkeeping.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state        <= ST_IDLE;
      cnt_we       <= ~CNT_OWNS;
      cnt_trig     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      count_q      <= '0;
      periods_seen <= '0;
      limit_q      <= '0;
      periods_q    <= '0;
    end else begin
      state    <= state_nx;
      cnt_we   <= (state_nx == ST_RUN) ? CNT_OWNS : ~CNT_OWNS;
      cnt_trig <= (state_nx == ST_ARM);
      busy     <= (state_nx != ST_IDLE);
      done     <= (state_nx == ST_STOP);

      if ((state == ST_IDLE) && start) begin
        limit_q      <= limit;
        periods_q    <= periods;
        periods_seen <= '0;
      end

      if (state == ST_RUN) begin
        count_q <= cnt_bus;
        if (cnt_pulse) periods_seen <= seen_inc;
      end
    end
  end

endmodule
